riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load/store unit on the memory side of the core's data interface. It accepts the core's request (req/we/size/addr/wd) and drives word-addressed data memory with byte enables and lane-replicated store data. It holds the core with stall until memory signals ready, then returns sign- or zero-extended load data. Misaligned/illegal accesses and memory timeouts are completed without a memory transaction and flagged.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles waiting for mem_ready_i before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low
core_req_i  input  1  core memory request; held stable while core_stall_o=1
core_we_i  input  1  1=store, 0=load
core_size_i  input  3  0=B, 1=H, 2=W, 4=BU, 5=HU; 3/6/7 illegal
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, right-aligned
core_rd_o  output  32  formatted load data, valid in completion cycle
core_stall_o  output  1  hold core (PC and RF write blocked)
err_o  output  1  one-cycle pulse: misaligned/illegal access or timeout
mem_req_o  output  1  memory request, level, held until accepted
mem_we_o  output  1  memory write
mem_be_o  output  4  byte enables
mem_addr_o  output  32  {core_addr_i[31:2],2'b00}
mem_wd_o  output  32  lane-replicated store data
mem_rd_i  input  32  memory read word
mem_ready_i  input  1  memory completion pulse; ignored in IDLE

Behaviour:
- Reset (rst_i=0 at edge): state=IDLE, counter=0. While rst_i=0, all outputs are 0.
- Access is bad when: size illegal; H/HU with addr[0]=1; W with addr[1:0]!=0.
- IDLE, core_req_i=1, access good: mem_req_o=1, core_stall_o=1. Next state is BUSY and counter=0.
- IDLE, core_req_i=1, access bad: mem_req_o=0, core_stall_o=0, err_o=1, core_rd_o=0. State stays IDLE.
- IDLE, core_req_i=0: all outputs 0.
- BUSY: mem_req_o=1 and mem_we_o=core_we_i, both held.
  - If mem_ready_i=1: core_stall_o=0, core_rd_o=formatted mem_rd_i, next state IDLE.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: core_stall_o=0, err_o=1, core_rd_o=0, mem_req_o=0 in this cycle, next state IDLE.
  - Else: core_stall_o=1 and counter increments.
  - mem_ready_i and timeout in the same cycle: ready wins and err_o=0.
- Latency: a good access takes at least 2 cycles (1 stall cycle). Back-to-back requests get no idle gap: IDLE with core_req_i=1 in the cycle after completion starts a new access.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0]
  - H/HU: 4'b0011<<{addr[1],1'b0}
  - W: 4'b1111
  - Loads also drive these enables.
- Store data:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load formatting: byte = mem_rd_i[8*addr[1:0] +: 8]; half = mem_rd_i[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- core_rd_o=0 in every cycle other than a good load completion.
- Outputs are combinational from state and inputs. Only state and counter are registered.

Test Plan:
- Load W, addr 0x100, mem_ready_i 3 cycles after req, mem_rd_i=0xDEADBEEF -> stall=1 for 3 cycles, then stall=0, core_rd_o=0xDEADBEEF, mem_be_o=4'hF, mem_addr_o=0x100.
- Store B, addr 0x203, wd=0x12345678, ready after 1 cycle -> mem_we_o=1, mem_be_o=4'b1000, mem_wd_o=0x78787878, mem_addr_o=0x200, stall exactly 1 cycle.
- Loads at addr 0x2, mem_rd_i=0x80FF7F01:
  - H -> 0xFFFF80FF
  - HU -> 0x000080FF
  - addr 0x1: B -> 0x0000007F
  - addr 0x3: B -> 0xFFFFFF80, BU -> 0x00000080
- Misaligned/illegal: W at 0x102, H at 0x101, size=3 -> mem_req_o=0, core_stall_o=0, err_o=1 in the same cycle, state stays IDLE.
- Timeout (TIMEOUT_CYCLES=4), mem_ready_i never asserted -> stall=1 for 3 BUSY cycles, 4th BUSY cycle stall=0, err_o=1, mem_req_o=0; ready on the 4th cycle instead -> normal completion, err_o=0.
- Reset mid-access: rst_i=0 during BUSY -> next cycle IDLE, all outputs 0. A late mem_ready_i after reset is ignored, and a new request then sequences normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and word-addressed data memory.
// Two-state sequencer with a wait counter; all outputs are combinational.
module riscv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              bad;
   logic              timeout_hit;
   logic [3:0]        be;
   logic [31:0]       wd_rep;
   logic [31:0]       rd_fmt;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   // Access decode: alignment check, lane enables, store replication, load extraction.
   always_comb begin
      bad      = 1'b0;
      be       = 4'b0000;
      wd_rep   = core_wd_i;
      rd_fmt   = mem_rd_i;
      byte_sel = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
      half_sel = mem_rd_i[{core_addr_i[1], 4'b0000} +: 16];
      case (core_size_i)
         3'd0, 3'd4: begin
            be     = 4'b0001 << core_addr_i[1:0];
            wd_rep = {4{core_wd_i[7:0]}};
            rd_fmt = core_size_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         3'd1, 3'd5: begin
            bad    = core_addr_i[0];
            be     = 4'b0011 << {core_addr_i[1], 1'b0};
            wd_rep = {2{core_wd_i[15:0]}};
            rd_fmt = core_size_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         3'd2: begin
            bad    = |core_addr_i[1:0];
            be     = 4'b1111;
         end
         default: bad = 1'b1;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (core_req_i && !bad) state_d = BUSY;
         end
         BUSY: begin
            if (mem_ready_i || timeout_hit) state_d = IDLE;
            else                            cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready has priority over timeout; the bus is only driven for a good access.
   always_comb begin
      core_rd_o    = '0;
      core_stall_o = 1'b0;
      err_o        = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0000;
      mem_addr_o   = '0;
      mem_wd_o     = '0;
      if (rst_i) begin
         case (state_q)
            IDLE: begin
               if (core_req_i) begin
                  if (bad) begin
                     err_o = 1'b1;
                  end else begin
                     mem_req_o    = 1'b1;
                     core_stall_o = 1'b1;
                     mem_we_o     = core_we_i;
                     mem_be_o     = be;
                     mem_addr_o   = {core_addr_i[31:2], 2'b00};
                     mem_wd_o     = wd_rep;
                  end
               end
            end
            BUSY: begin
               mem_be_o   = be;
               mem_addr_o = {core_addr_i[31:2], 2'b00};
               mem_wd_o   = wd_rep;
               if (mem_ready_i) begin
                  mem_req_o = 1'b1;
                  mem_we_o  = core_we_i;
                  core_rd_o = core_we_i ? 32'b0 : rd_fmt;
               end else if (timeout_hit) begin
                  err_o = 1'b1;
               end else begin
                  mem_req_o    = 1'b1;
                  mem_we_o     = core_we_i;
                  core_stall_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
